ctrl_sched_load: RTL and testbench

Schedule loader that sits directly upstream of the 15-point time/value control muxer stage. It accepts (time, value) breakpoint writes from the host interface into a shadow bank and, on commit, checks that the 15 breakpoint times are valid. A valid schedule is copied to the active bank, which drives `time_1..15` / `value_1..15`, only on a simulation-step boundary, so the downstream stage never sees a partially updated schedule.

---
 rtl/ctrl_sched_load_if.sv | 25 ++
 rtl/ctrl_sched_load.sv | 191 +++++++++++++++++++
 tb/tb_ctrl_sched_load.sv | 271 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/ctrl_sched_load_if.sv
// Host-side bus of the schedule loader: breakpoint writes, commit/step handshake
// and the loader's status outputs.
interface ctrl_sched_load_if #(
  parameter int W_VAL = 64
);
  logic             wr_en;
  logic [3:0]       wr_addr;
  logic [11:0]      wr_time;
  logic [W_VAL-1:0] wr_value;
  logic             commit;
  logic             step_sync;
  logic             busy;
  logic             loaded;
  logic [1:0]       err;

  modport master (
    output wr_en, wr_addr, wr_time, wr_value, commit, step_sync,
    input  busy, loaded, err
  );

  modport slave (
    input  wr_en, wr_addr, wr_time, wr_value, commit, step_sync,
    output busy, loaded, err
  );
endinterface

// File: rtl/ctrl_sched_load.sv
// Shadow/active breakpoint schedule loader: validates a committed shadow bank one
// entry per cycle and copies it to the active bank on a simulation-step boundary.
module ctrl_sched_load #(
  parameter int W_VAL = 64,  // EXTENDED_SINGLE
  parameter int N_PT  = 15
) (
  input  logic             clk,
  input  logic             sta,
  ctrl_sched_load_if.slave bus,
  output logic [11:0]      time_1,
  output logic [11:0]      time_2,
  output logic [11:0]      time_3,
  output logic [11:0]      time_4,
  output logic [11:0]      time_5,
  output logic [11:0]      time_6,
  output logic [11:0]      time_7,
  output logic [11:0]      time_8,
  output logic [11:0]      time_9,
  output logic [11:0]      time_10,
  output logic [11:0]      time_11,
  output logic [11:0]      time_12,
  output logic [11:0]      time_13,
  output logic [11:0]      time_14,
  output logic [11:0]      time_15,
  output logic [W_VAL-1:0] value_1,
  output logic [W_VAL-1:0] value_2,
  output logic [W_VAL-1:0] value_3,
  output logic [W_VAL-1:0] value_4,
  output logic [W_VAL-1:0] value_5,
  output logic [W_VAL-1:0] value_6,
  output logic [W_VAL-1:0] value_7,
  output logic [W_VAL-1:0] value_8,
  output logic [W_VAL-1:0] value_9,
  output logic [W_VAL-1:0] value_10,
  output logic [W_VAL-1:0] value_11,
  output logic [W_VAL-1:0] value_12,
  output logic [W_VAL-1:0] value_13,
  output logic [W_VAL-1:0] value_14,
  output logic [W_VAL-1:0] value_15
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_CHECK,
    S_WAIT_SYNC,
    S_APPLY
  } state_e;

  localparam logic [1:0] ERR_NONE  = 2'd0;
  localparam logic [1:0] ERR_ORDER = 2'd1;
  localparam logic [1:0] ERR_BUSY  = 2'd2;
  localparam logic [1:0] ERR_ADDR  = 2'd3;

  state_e           state_q, state_d;
  logic [3:0]       k_q, k_d;
  logic [1:0]       err_q, err_d;
  logic             loaded_q, loaded_d;
  logic             entry_fail;

  logic [11:0]      shadow_time_q  [1:N_PT];
  logic [11:0]      shadow_time_d  [1:N_PT];
  logic [W_VAL-1:0] shadow_value_q [1:N_PT];
  logic [W_VAL-1:0] shadow_value_d [1:N_PT];
  logic [11:0]      active_time_q  [1:N_PT];
  logic [11:0]      active_time_d  [1:N_PT];
  logic [W_VAL-1:0] active_value_q [1:N_PT];
  logic [W_VAL-1:0] active_value_d [1:N_PT];

  // NOTE: every signal gets its default before the case so no path leaves one unassigned (no latches).
  always_comb begin
    state_d        = state_q;
    k_d            = k_q;
    err_d          = err_q;
    loaded_d       = 1'b0;
    entry_fail     = 1'b0;
    shadow_time_d  = shadow_time_q;
    shadow_value_d = shadow_value_q;
    active_time_d  = active_time_q;
    active_value_d = active_value_q;

    case (state_q)
      S_IDLE: begin
        if (bus.wr_en) begin
          if (bus.wr_addr == 4'd0) begin
            err_d = ERR_ADDR;
          end else begin
            shadow_time_d[bus.wr_addr]  = bus.wr_time;
            shadow_value_d[bus.wr_addr] = bus.wr_value;
          end
        end
        // A same-cycle write lands in the shadow before CHECK reads it.
        if (bus.commit) begin
          err_d   = ERR_NONE;
          k_d     = 4'd1;
          state_d = S_CHECK;
        end
      end

      S_CHECK: begin
        if (bus.wr_en || bus.commit) err_d = ERR_BUSY;
        entry_fail = (shadow_time_q[k_q] == 12'd0) ||
                     ((k_q != 4'd1) && (shadow_time_q[k_q] <= shadow_time_q[k_q - 4'd1]));
        if (entry_fail) begin
          err_d   = ERR_ORDER;
          state_d = S_IDLE;
        end else if (k_q == 4'(N_PT)) begin
          state_d = S_WAIT_SYNC;
        end else begin
          k_d = k_q + 4'd1;
        end
      end

      S_WAIT_SYNC: begin
        if (bus.wr_en || bus.commit) err_d = ERR_BUSY;
        if (bus.step_sync) state_d = S_APPLY;
      end

      S_APPLY: begin
        if (bus.wr_en || bus.commit) err_d = ERR_BUSY;
        active_time_d  = shadow_time_q;
        active_value_d = shadow_value_q;
        loaded_d       = 1'b1;
        state_d        = S_IDLE;
      end

      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so all flops update from pre-edge values.
  always_ff @(posedge clk or posedge sta) begin
    if (sta) begin
      state_q  <= S_IDLE;
      k_q      <= 4'd1;
      err_q    <= ERR_NONE;
      loaded_q <= 1'b0;
      // NOTE: both banks are reset so the downstream stage sees a known all-inactive schedule.
      for (int i = 1; i <= N_PT; i++) begin
        shadow_time_q[i]  <= 12'hFFF;
        shadow_value_q[i] <= '0;
        active_time_q[i]  <= 12'hFFF;
        active_value_q[i] <= '0;
      end
    end else begin
      state_q        <= state_d;
      k_q            <= k_d;
      err_q          <= err_d;
      loaded_q       <= loaded_d;
      shadow_time_q  <= shadow_time_d;
      shadow_value_q <= shadow_value_d;
      active_time_q  <= active_time_d;
      active_value_q <= active_value_d;
    end
  end

  assign bus.busy   = (state_q != S_IDLE);
  assign bus.loaded = loaded_q;
  assign bus.err    = err_q;

  assign time_1   = active_time_q[1];
  assign time_2   = active_time_q[2];
  assign time_3   = active_time_q[3];
  assign time_4   = active_time_q[4];
  assign time_5   = active_time_q[5];
  assign time_6   = active_time_q[6];
  assign time_7   = active_time_q[7];
  assign time_8   = active_time_q[8];
  assign time_9   = active_time_q[9];
  assign time_10  = active_time_q[10];
  assign time_11  = active_time_q[11];
  assign time_12  = active_time_q[12];
  assign time_13  = active_time_q[13];
  assign time_14  = active_time_q[14];
  assign time_15  = active_time_q[15];
  assign value_1  = active_value_q[1];
  assign value_2  = active_value_q[2];
  assign value_3  = active_value_q[3];
  assign value_4  = active_value_q[4];
  assign value_5  = active_value_q[5];
  assign value_6  = active_value_q[6];
  assign value_7  = active_value_q[7];
  assign value_8  = active_value_q[8];
  assign value_9  = active_value_q[9];
  assign value_10 = active_value_q[10];
  assign value_11 = active_value_q[11];
  assign value_12 = active_value_q[12];
  assign value_13 = active_value_q[13];
  assign value_14 = active_value_q[14];
  assign value_15 = active_value_q[15];

endmodule

// File: tb/tb_ctrl_sched_load.sv
// Scoreboard bench for ctrl_sched_load: the driver predicts each commit's outcome from
// a shadow/active bank model; a monitor checks it whenever busy falls.
module tb_ctrl_sched_load;
  localparam int W = 64;

  logic clk = 1'b0;
  logic sta = 1'b1;
  always #5 clk = ~clk;

  ctrl_sched_load_if #(.W_VAL(W)) bus ();

  logic [11:0] time_1, time_2, time_3, time_4, time_5, time_6, time_7, time_8;
  logic [11:0] time_9, time_10, time_11, time_12, time_13, time_14, time_15;
  logic [W-1:0] value_1, value_2, value_3, value_4, value_5, value_6, value_7, value_8;
  logic [W-1:0] value_9, value_10, value_11, value_12, value_13, value_14, value_15;

  ctrl_sched_load #(.W_VAL(W), .N_PT(15)) dut (
    .clk(clk), .sta(sta), .bus(bus),
    .time_1(time_1), .time_2(time_2), .time_3(time_3), .time_4(time_4), .time_5(time_5),
    .time_6(time_6), .time_7(time_7), .time_8(time_8), .time_9(time_9), .time_10(time_10),
    .time_11(time_11), .time_12(time_12), .time_13(time_13), .time_14(time_14), .time_15(time_15),
    .value_1(value_1), .value_2(value_2), .value_3(value_3), .value_4(value_4), .value_5(value_5),
    .value_6(value_6), .value_7(value_7), .value_8(value_8), .value_9(value_9), .value_10(value_10),
    .value_11(value_11), .value_12(value_12), .value_13(value_13), .value_14(value_14),
    .value_15(value_15)
  );

  wire [15:1][11:0] t_out = {time_15, time_14, time_13, time_12, time_11, time_10, time_9,
                             time_8, time_7, time_6, time_5, time_4, time_3, time_2, time_1};
  wire [15:1][W-1:0] v_out = {value_15, value_14, value_13, value_12, value_11, value_10, value_9,
                              value_8, value_7, value_6, value_5, value_4, value_3, value_2, value_1};

  typedef struct {
    logic [15:1][11:0]  t;
    logic [15:1][W-1:0] v;
    logic [1:0]         err;
    logic               loaded;
    int                 len;     // busy cycles expected; 0 = not checked (reset abort)
  } exp_t;

  exp_t exp_q[$];

  // Reference model: shadow and active banks plus sticky error.
  logic [15:1][11:0]  m_st, m_at;
  logic [15:1][W-1:0] m_sv, m_av;
  logic [1:0]         m_err;

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic model_reset();
    m_st  = {15{12'hFFF}};
    m_at  = {15{12'hFFF}};
    m_sv  = '0;
    m_av  = '0;
    m_err = 2'd0;
  endtask

  // A schedule is good when every time is nonzero and times strictly increase.
  function automatic int first_fail();
    for (int k = 1; k <= 15; k++) begin
      if (m_st[k] == 12'd0) return k;
      if (k > 1 && m_st[k] <= m_st[k-1]) return k;
    end
    return 0;
  endfunction

  task automatic wr(input logic [3:0] a, input logic [11:0] t, input logic [W-1:0] v);
    bus.wr_en = 1'b1; bus.wr_addr = a; bus.wr_time = t; bus.wr_value = v;
    tick();
    bus.wr_en = 1'b0;
    if (a == 4'd0) m_err = 2'd3;
    else begin m_st[a] = t; m_sv[a] = v; end
  endtask

  // Commit (optionally with a same-cycle write), then pulse step_sync so it is
  // sampled w cycles after the last CHECK edge; inj disturbs the bus during WAIT_SYNC.
  task automatic run_commit(input int w, input bit inj, input bit with_wr,
                            input logic [3:0] wa, input logic [11:0] wt, input logic [W-1:0] wv);
    exp_t e;
    int   f;
    bus.commit = 1'b1;
    if (with_wr) begin
      bus.wr_en = 1'b1; bus.wr_addr = wa; bus.wr_time = wt; bus.wr_value = wv;
    end
    tick();
    bus.commit = 1'b0;
    bus.wr_en  = 1'b0;
    if (with_wr) begin m_st[wa] = wt; m_sv[wa] = wv; end
    f = first_fail();
    if (f != 0) begin
      e.t = m_at; e.v = m_av; e.err = 2'd1; e.loaded = 1'b0; e.len = f;
      m_err = 2'd1;
      exp_q.push_back(e);
      repeat (f + 1) tick();
    end else begin
      e.t = m_st; e.v = m_sv; e.err = inj ? 2'd2 : 2'd0; e.loaded = 1'b1; e.len = 16 + w;
      m_at = m_st; m_av = m_sv; m_err = e.err;
      exp_q.push_back(e);
      repeat (15) tick();
      for (int i = 1; i < w; i++) begin
        if (inj && i == 1) begin
          bus.wr_en = 1'b1; bus.wr_addr = 4'd3; bus.wr_time = 12'($urandom);
          bus.wr_value = {$urandom, $urandom}; bus.commit = 1'($urandom);
        end
        tick();
        bus.wr_en = 1'b0; bus.commit = 1'b0;
      end
      bus.step_sync = 1'b1;
      tick();
      bus.step_sync = 1'b0;
      repeat (2) tick();
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    for (int k = 1; k <= 15; k++) begin
      check($sformatf("%s_time_%0d", tag, k), W'(t_out[k]), W'(12'hFFF));
      check($sformatf("%s_value_%0d", tag, k), v_out[k], '0);
    end
    check({tag, "_busy"}, W'(bus.busy), '0);
    check({tag, "_loaded"}, W'(bus.loaded), '0);
    check({tag, "_err"}, W'(bus.err), '0);
  endtask

  // Monitor: every busy->idle transition resolves exactly one expected outcome.
  bit prev_busy = 1'b0;
  int run = 0;
  always @(negedge clk) begin
    automatic bit fell = prev_busy && (bus.busy !== 1'b1);
    exp_t e;
    if (bus.loaded === 1'b1 && !fell) check("loaded_without_apply", W'(bus.loaded), '0);
    if (fell) begin
      if (exp_q.size() == 0) begin
        check("unexpected_busy_fall", W'(exp_q.size()), W'(1));
      end else begin
        e = exp_q.pop_front();
        check("loaded", W'(bus.loaded), W'(e.loaded));
        check("err", W'(bus.err), W'(e.err));
        if (e.len > 0) check("busy_cycles", W'(run), W'(e.len));
        for (int k = 1; k <= 15; k++) begin
          check($sformatf("time_%0d", k), W'(t_out[k]), W'(e.t[k]));
          check($sformatf("value_%0d", k), v_out[k], e.v[k]);
        end
      end
      run = 0;
    end else if (bus.busy === 1'b1) begin
      run++;
    end
    prev_busy = (bus.busy === 1'b1);
  end

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

  initial begin
    logic [15:1][11:0]  des_t;
    logic [15:1][W-1:0] des_v;
    logic [11:0]        t;
    int                 cnt;
    bit                 with_wr, inj;
    logic [3:0]         wa;
    int                 j, w;

    bus.wr_en = 1'b0; bus.wr_addr = '0; bus.wr_time = '0; bus.wr_value = '0;
    bus.commit = 1'b0; bus.step_sync = 1'b0;
    model_reset();

    repeat (3) tick();
    check_reset_outputs("reset");
    sta = 1'b0;
    tick();

    // Ramp schedule: time 10k, value k; step_sync 5 cycles into WAIT_SYNC.
    for (int k = 1; k <= 15; k++) wr(4'(k), 12'(10 * k), W'(k));
    run_commit(5, 1'b0, 1'b0, '0, '0, '0);
    check("time_7_ramp", W'(time_7), W'(70));
    check("value_7_ramp", value_7, W'(7));

    // Equal neighbour times fail at entry 5.
    wr(4'd5, 12'd40, W'(5));
    run_commit(1, 1'b0, 1'b0, '0, '0, '0);
    check("busy_after_fail", W'(bus.busy), '0);

    // Zero time at entry 1 fails immediately.
    wr(4'd5, 12'd50, W'(5));
    wr(4'd1, 12'd0, W'(1));
    run_commit(1, 1'b0, 1'b0, '0, '0, '0);

    // Write to entry 3 during WAIT_SYNC is dropped and flags err 2.
    wr(4'd1, 12'd10, W'(1));
    wr(4'd3, 12'd33, W'(333));
    run_commit(4, 1'b1, 1'b0, '0, '0, '0);

    // Address 0 is rejected; the next good commit clears err.
    wr(4'd0, 12'h123, W'(99));
    check("err_bad_addr", W'(bus.err), W'(m_err));
    run_commit(1, 1'b0, 1'b0, '0, '0, '0);

    // Reset during WAIT_SYNC abandons the commit.
    for (int k = 1; k <= 15; k++) wr(4'(k), 12'(20 * k), W'(100 + k));
    bus.commit = 1'b1;
    tick();
    bus.commit = 1'b0;
    repeat (17) tick();
    begin
      exp_t e;
      e.t = {15{12'hFFF}}; e.v = '0; e.err = 2'd0; e.loaded = 1'b0; e.len = 0;
      exp_q.push_back(e);
    end
    sta = 1'b1;
    #1;
    check_reset_outputs("abort");
    model_reset();
    tick();
    sta = 1'b0;
    bus.step_sync = 1'b1;
    tick();
    bus.step_sync = 1'b0;
    cnt = 0;
    for (int i = 0; i < 5; i++) begin
      if (bus.loaded === 1'b1) cnt++;
      tick();
    end
    check("no_loaded_after_abort", W'(cnt), '0);

    // Randomized schedules: partial rewrites, same-cycle write+commit, order faults.
    for (int it = 0; it < 40; it++) begin
      t = 12'd0;
      for (int k = 1; k <= 15; k++) begin
        t = t + 12'($urandom_range(1, 250));
        des_t[k] = t;
        des_v[k] = ($urandom_range(0, 1) == 1) ? {$urandom, $urandom} : m_sv[k];
      end
      if ($urandom_range(0, 3) == 0) begin
        j = $urandom_range(1, 15);
        des_t[j] = (j == 1 || $urandom_range(0, 1) == 1) ? 12'd0 : des_t[j-1];
      end
      with_wr = 1'($urandom);
      wa      = 4'($urandom_range(1, 15));
      for (int k = 1; k <= 15; k++) begin
        if (!(with_wr && 4'(k) == wa) && (m_st[k] != des_t[k] || m_sv[k] != des_v[k]))
          wr(4'(k), des_t[k], des_v[k]);
      end
      w   = $urandom_range(1, 6);
      inj = (w >= 2) && ($urandom_range(0, 3) == 0);
      run_commit(w, inj, with_wr, wa, des_t[wa], des_v[wa]);
    end

    repeat (4) tick();
    check("scoreboard_drained", W'(exp_q.size()), '0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
